mem_stage: RTL and testbench

- Pipeline MEM stage, directly downstream of the execute stage.
- Consumes the execute stage's registered outputs: ALU result, rs2 data, rd address, reg_write, mem_write and wb mux select.
- Performs loads and stores over a req/ack data-memory port, including byte-lane steering and load sign/zero extension.
- Stalls the pipeline while a memory access is outstanding, and registers the results into the WB stage.

---
 rtl/mem_stage.sv | 201 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores over a req/ack data-memory port,
// steers byte lanes, extends load data and registers results into WB.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_addr,
    input  logic        reg_write,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [2:0]  mem_funct3,
    input  logic [1:0]  wb_mux,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        stall,
    output logic [31:0] forward_mem,
    output logic [4:0]  rd_addr_out,
    output logic        reg_write_out,
    output logic [31:0] alu_out_wb,
    output logic [31:0] load_data_out,
    output logic [1:0]  wb_mux_out,
    output logic        misalign
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        w_access;
    logic        w_is_load;
    logic        w_misalign;
    logic        w_start;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_byte_shift;
    logic [31:0] w_half_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    logic        r_dmem_we;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_dmem_wdata;
    logic [3:0]  r_dmem_be;
    logic [4:0]  r_rd_addr;
    logic        r_reg_write;
    logic [31:0] r_alu;
    logic [31:0] r_load_data;
    logic [1:0]  r_wb_mux;
    logic        r_misalign;

    // A simultaneous read+write request is handled as a store.
    assign w_access  = mem_read | mem_write;
    assign w_is_load = mem_read & ~mem_write;
    assign w_start   = (r_state == S_IDLE) && w_access && !w_misalign;

    always_comb begin
        w_misalign = 1'b0;
        if (w_access) begin
            case (mem_funct3)
                3'b000, 3'b100: w_misalign = 1'b0;
                3'b001, 3'b101: w_misalign = alu_result[0];
                3'b010:         w_misalign = |alu_result[1:0];
                default:        w_misalign = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = rs2_data;
        if (mem_write) begin
            case (mem_funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << alu_result[1:0];
                    w_wdata = {4{rs2_data[7:0]}};
                end
                2'b01: begin
                    w_be    = alu_result[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{rs2_data[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = rs2_data;
                end
            endcase
        end
    end

    assign w_byte_shift = dmem_rdata >> {alu_result[1:0], 3'b000};
    assign w_half_shift = dmem_rdata >> {alu_result[1], 4'b0000};
    assign w_byte       = w_byte_shift[7:0];
    assign w_half       = w_half_shift[15:0];

    always_comb begin
        w_load_data = 32'h0;
        if (w_is_load) begin
            case (mem_funct3)
                3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
                3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
                3'b010:  w_load_data = dmem_rdata;
                3'b100:  w_load_data = {24'h0, w_byte};
                3'b101:  w_load_data = {16'h0, w_half};
                default: w_load_data = 32'h0;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    stall        = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = ~dmem_ack;
                if (dmem_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= 32'h0;
            r_dmem_wdata <= 32'h0;
            r_dmem_be    <= 4'h0;
            r_rd_addr    <= 5'h0;
            r_reg_write  <= 1'b0;
            r_alu        <= 32'h0;
            r_load_data  <= 32'h0;
            r_wb_mux     <= 2'h0;
            r_misalign   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_misalign <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_dmem_we    <= mem_write;
                        r_dmem_addr  <= {alu_result[31:2], 2'b00};
                        r_dmem_wdata <= w_wdata;
                        r_dmem_be    <= w_be;
                        // Bubble into WB until the memory completes.
                        r_rd_addr    <= 5'h0;
                        r_reg_write  <= 1'b0;
                        r_alu        <= 32'h0;
                        r_load_data  <= 32'h0;
                        r_wb_mux     <= 2'h0;
                    end else begin
                        r_rd_addr   <= rd_addr;
                        r_reg_write <= reg_write & ~w_misalign;
                        r_alu       <= alu_result;
                        r_load_data <= 32'h0;
                        r_wb_mux    <= wb_mux;
                        r_misalign  <= w_misalign;
                    end
                end
                S_BUSY: begin
                    if (dmem_ack) begin
                        r_rd_addr   <= rd_addr;
                        r_reg_write <= reg_write;
                        r_alu       <= alu_result;
                        r_load_data <= w_load_data;
                        r_wb_mux    <= wb_mux;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem_req      = (r_state == S_BUSY);
    assign dmem_we       = r_dmem_we;
    assign dmem_addr     = r_dmem_addr;
    assign dmem_wdata    = r_dmem_wdata;
    assign dmem_be       = r_dmem_be;
    assign forward_mem   = alu_result;
    assign rd_addr_out   = r_rd_addr;
    assign reg_write_out = r_reg_write;
    assign alu_out_wb    = r_alu;
    assign load_data_out = r_load_data;
    assign wb_mux_out    = r_wb_mux;
    assign misalign      = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected WB results are queued when an
// instruction is driven and compared when the stage writes it back.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result, rs2_data, dmem_rdata;
    logic [4:0]  rd_addr;
    logic        reg_write, mem_write, mem_read, dmem_ack;
    logic [2:0]  mem_funct3;
    logic [1:0]  wb_mux;
    logic        dmem_req, dmem_we, stall, reg_write_out, misalign;
    logic [31:0] dmem_addr, dmem_wdata, forward_mem, alu_out_wb, load_data_out;
    logic [3:0]  dmem_be;
    logic [4:0]  rd_addr_out;
    logic [1:0]  wb_mux_out;

    typedef struct packed {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [1:0]  wbm;
    } wb_t;

    wb_t sb_q[$];
    int  tests = 0;
    int  fails = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .alu_result(alu_result), .rs2_data(rs2_data), .rd_addr(rd_addr),
        .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read),
        .mem_funct3(mem_funct3), .wb_mux(wb_mux),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .stall(stall),
        .forward_mem(forward_mem), .rd_addr_out(rd_addr_out),
        .reg_write_out(reg_write_out), .alu_out_wb(alu_out_wb),
        .load_data_out(load_data_out), .wb_mux_out(wb_mux_out),
        .misalign(misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nop();
        alu_result = 32'h0; rs2_data = 32'h0; rd_addr = 5'h0; reg_write = 1'b0;
        mem_write = 1'b0; mem_read = 1'b0; mem_funct3 = 3'b000; wb_mux = 2'b00;
    endtask

    task automatic drive(input logic [31:0] ea, input logic [31:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic mw, input logic mr,
                         input logic [2:0] f3, input logic [1:0] wbm);
        alu_result = ea; rs2_data = rs2; rd_addr = rd; reg_write = rw;
        mem_write = mw; mem_read = mr; mem_funct3 = f3; wb_mux = wbm;
    endtask

    task automatic compare_wb(input string tag);
        wb_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_rd"},   {27'h0, rd_addr_out},   {27'h0, e.rd});
            check({tag, "_rw"},   {31'h0, reg_write_out}, {31'h0, e.rw});
            check({tag, "_alu"},  alu_out_wb,             e.alu);
            check({tag, "_load"}, load_data_out,          e.ld);
            check({tag, "_wbm"},  {30'h0, wb_mux_out},    {30'h0, e.wbm});
            $display("[TB] %s: rd=%0d rw=%0b alu=%h load=%h wbm=%0d",
                     tag, rd_addr_out, reg_write_out, alu_out_wb, load_data_out, wb_mux_out);
        end
    endtask

    // Non-memory instruction: one-cycle pass-through, no stall.
    task automatic alu_op(input string tag, input logic [31:0] alu, input logic [4:0] rd,
                          input logic rw, input logic [1:0] wbm);
        drive(alu, 32'h0, rd, rw, 1'b0, 1'b0, 3'b000, wbm);
        @(negedge clk);
        check({tag, "_stall"}, {31'h0, stall}, 32'd0);
        check({tag, "_req"}, {31'h0, dmem_req}, 32'd0);
        check({tag, "_fwd"}, forward_mem, alu);
        sb_q.push_back('{rd: rd, rw: rw, alu: alu, ld: 32'h0, wbm: wbm});
        @(posedge clk); #1;
        nop();
        @(negedge clk);
        compare_wb(tag);
        check({tag, "_misalign"}, {31'h0, misalign}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Legal memory access, acked on BUSY cycle ack_at.
    task automatic mem_op(input string tag, input logic [31:0] ea, input logic [31:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic mw, input logic mr,
                          input logic [2:0] f3, input logic [1:0] wbm, input logic [31:0] rdata,
                          input int ack_at, input logic exp_we, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_load,
                          input int exp_stalls);
        int stalls = 0;
        drive(ea, rs2, rd, rw, mw, mr, f3, wbm);
        dmem_ack = 1'b0;
        @(negedge clk);
        check({tag, "_stall_idle"}, {31'h0, stall}, 32'd1);
        check({tag, "_req_idle"}, {31'h0, dmem_req}, 32'd0);
        if (stall) stalls++;
        sb_q.push_back('{rd: rd, rw: rw, alu: ea, ld: exp_load, wbm: wbm});
        for (int c = 1; c <= ack_at; c++) begin
            @(posedge clk); #1;
            dmem_ack   = (c == ack_at);
            dmem_rdata = (c == ack_at) ? rdata : 32'hDEADBEEF;
            @(negedge clk);
            check({tag, "_req"},   {31'h0, dmem_req}, 32'd1);
            check({tag, "_we"},    {31'h0, dmem_we}, {31'h0, exp_we});
            check({tag, "_addr"},  dmem_addr, {ea[31:2], 2'b00});
            check({tag, "_be"},    {28'h0, dmem_be}, {28'h0, exp_be});
            check({tag, "_wdata"}, dmem_wdata, exp_wdata);
            check({tag, "_bubble"}, {31'h0, reg_write_out}, 32'd0);
            check({tag, "_stall"}, {31'h0, stall}, (c == ack_at) ? 32'd0 : 32'd1);
            check({tag, "_fwd"}, forward_mem, ea);
            if (stall) stalls++;
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        nop();
        @(negedge clk);
        compare_wb(tag);
        check({tag, "_req_done"}, {31'h0, dmem_req}, 32'd0);
        check({tag, "_stall_cycles"}, stalls, exp_stalls);
        @(posedge clk); #1;
    endtask

    // Misaligned/illegal access: no request, one-cycle misalign pulse.
    task automatic mis_op(input string tag, input logic [31:0] ea, input logic [4:0] rd,
                          input logic mw, input logic mr, input logic [2:0] f3,
                          input logic [1:0] wbm);
        drive(ea, 32'h55555555, rd, 1'b1, mw, mr, f3, wbm);
        @(negedge clk);
        check({tag, "_stall"}, {31'h0, stall}, 32'd0);
        check({tag, "_req"}, {31'h0, dmem_req}, 32'd0);
        sb_q.push_back('{rd: rd, rw: 1'b0, alu: ea, ld: 32'h0, wbm: wbm});
        @(posedge clk); #1;
        nop();
        @(negedge clk);
        check({tag, "_pulse"}, {31'h0, misalign}, 32'd1);
        check({tag, "_req2"}, {31'h0, dmem_req}, 32'd0);
        compare_wb(tag);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_pulse_end"}, {31'h0, misalign}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        nop();
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'h0, dmem_req}, 32'd0);
        check("rst_stall", {31'h0, stall}, 32'd0);
        check("rst_rw", {31'h0, reg_write_out}, 32'd0);
        check("rst_alu", alu_out_wb, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        $display("[TB] reset: req=%0b stall=%0b rw=%0b", dmem_req, stall, reg_write_out);
        @(posedge clk); #1;
        rst = 1'b0;

        alu_op("alu1", 32'h12345678, 5'd5, 1'b1, 2'd0);
        alu_op("alu2", 32'hCAFEF00D, 5'd31, 1'b1, 2'd2);

        // LB 0x103, ack on third BUSY cycle
        mem_op("lb", 32'h103, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 3'b000, 2'd1, 32'h80FFFFFF,
               3, 1'b0, 4'b1111, 32'h0, 32'hFFFFFF80, 3);
        // LHU 0x202, ack on first BUSY cycle
        mem_op("lhu", 32'h202, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 3'b101, 2'd1, 32'hBEEF0000,
               1, 1'b0, 4'b1111, 32'h0, 32'h0000BEEF, 1);
        // SB 0x301
        mem_op("sb", 32'h301, 32'hAABBCCDD, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0,
               2, 1'b1, 4'b0010, 32'hDDDDDDDD, 32'h0, 2);
        // SH 0x302
        mem_op("sh", 32'h302, 32'h1234ABCD, 5'd0, 1'b0, 1'b1, 1'b0, 3'b001, 2'd0, 32'h0,
               1, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0, 1);
        // LH 0x100, sign-extended low half
        mem_op("lh", 32'h100, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 3'b001, 2'd1, 32'h00008001,
               2, 1'b0, 4'b1111, 32'h0, 32'hFFFF8001, 2);
        // LW 0x104
        mem_op("lw", 32'h104, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 3'b010, 2'd1, 32'h89ABCDEF,
               1, 1'b0, 4'b1111, 32'h0, 32'h89ABCDEF, 1);
        // LBU 0x102
        mem_op("lbu", 32'h102, 32'h0, 5'd13, 1'b1, 1'b0, 1'b1, 3'b100, 2'd1, 32'h00F50000,
               1, 1'b0, 4'b1111, 32'h0, 32'h000000F5, 1);

        mis_op("mis_lw", 32'h102, 5'd14, 1'b0, 1'b1, 3'b010, 2'd1);
        mis_op("mis_sh", 32'h201, 5'd15, 1'b1, 1'b0, 3'b001, 2'd0);
        mis_op("mis_ill", 32'h200, 5'd16, 1'b0, 1'b1, 3'b011, 2'd1);

        // Reset mid-BUSY, then a stray ack after release
        drive(32'h100, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 3'b010, 2'd1);
        @(negedge clk);
        check("rstb_stall_idle", {31'h0, stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstb_req_busy", {31'h0, dmem_req}, 32'd1);
        #2;
        rst = 1'b1;
        nop();
        #1;
        check("rstb_req", {31'h0, dmem_req}, 32'd0);
        check("rstb_stall", {31'h0, stall}, 32'd0);
        check("rstb_addr", dmem_addr, 32'd0);
        check("rstb_be", {28'h0, dmem_be}, 32'd0);
        check("rstb_rw", {31'h0, reg_write_out}, 32'd0);
        check("rstb_alu", alu_out_wb, 32'd0);
        check("rstb_load", load_data_out, 32'd0);
        $display("[TB] rst_mid_busy: req=%0b stall=%0b addr=%h", dmem_req, stall, dmem_addr);
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h11111111;
        @(negedge clk);
        check("stray_req", {31'h0, dmem_req}, 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        check("stray_rw", {31'h0, reg_write_out}, 32'd0);
        check("stray_load", load_data_out, 32'd0);
        check("stray_rd", {27'h0, rd_addr_out}, 32'd0);
        $display("[TB] stray_ack: rw=%0b load=%h", reg_write_out, load_data_out);

        check("sb_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
